ibus_copy_engine: RTL and testbench
===================================

# ibus_copy_engine

Single-channel block-copy initiator on the SH-2 internal peripheral bus (IBUS). It is the master end of the IBUS protocol that the on-chip register blocks (DIVU, timers, serial) answer as responders. The engine reads an element from a source address, writes it to a destination address, and repeats for a programmed count. It is used for register-file preload, such as feeding DVSR/DVDNT operands, and for memory-to-peripheral moves without CPU involvement.

## Interface
Parameters:
- CNT_W, default 24: transfer-count width; a count of 0 means 2^CNT_W elements.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; all state advances only on CE_R edges
- CE_F  in  1  falling-phase clock enable; unused internally, present for port uniformity
- RES_N  in  1  synchronous soft reset under CE_R, equivalent to RST_N
- START  in  1  launch request, sampled only in IDLE
- ABORT  in  1  stop request
- SAR  in  32  source start address
- DAR  in  32  destination start address
- TCR  in  CNT_W  element count
- SIZE  in  2  element size: 0 = byte, 1 = word, 2 = long, 3 = reserved (error)
- SM, DM  in  1 each  source/destination address mode: 0 = increment, 1 = fixed (see Configuration)
- IBUS_A  out  32  bus address
- IBUS_DO  out  32  write data
- IBUS_DI  in  32  read data from the selected responder
- IBUS_BA  out  4  byte lanes, big-endian: BA[3] = bits 31:24 = offset 0
- IBUS_WE  out  1  write strobe
- IBUS_REQ  out  1  access request
- IBUS_BUSY  in  1  responder wait
- ACTIVE  out  1  high while not IDLE
- DONE  out  1  one CE_R-period pulse on normal completion
- ERR  out  1  one CE_R-period pulse on address/size error or abort
- REMAIN  out  CNT_W  elements not yet written

## Operation
- States: IDLE, RD, WR.
- IDLE, START=1 at a CE_R edge:
  - Latch SAR, DAR, TCR, SIZE, SM, DM.
  - Error condition: SIZE=3, or SAR/DAR misaligned for SIZE (word needs A[0]=0; long needs A[1:0]=0).
  - On error: pulse ERR and stay in IDLE with no bus access.
  - Otherwise go to RD.
- RD drives:
  - REQ=1, WE=0, A = current source address.
  - BA: byte 1000>>A[1:0]; word 1100 or 0011 by A[1]; long 1111.
- RD completes at the first CE_R edge with IBUS_BUSY=0:
  - Capture the element from the lanes given by BA.
  - Go to WR.
- WR drives:
  - REQ=1, WE=1, A = current destination address, BA per destination alignment.
  - IBUS_DO: element replicated across lanes (byte ×4, word ×2).
- WR completes at the first CE_R edge with IBUS_BUSY=0:
  - REMAIN decrements.
  - Addresses advance by 1/2/4 unless held fixed; 32-bit wrap FFFFFFFC+4 → 00000000.
  - If REMAIN reaches 0, go to IDLE and pulse DONE; otherwise go to RD.
- TCR=0 transfers 2^CNT_W elements: REMAIN loads 0 and wraps on the first decrement.
- ABORT:
  - In RD: go to IDLE at that CE_R edge, pulse ERR, no write issued.
  - In WR: the write finishes (BUSY honoured), then go to IDLE and pulse ERR.
  - A write is never torn.
- START outside IDLE is ignored.
- ABORT and START together in IDLE: START wins.
- RES_N=0 or RST_N=0 drops REQ immediately, even mid-write; the responder sees the access vanish.

## Timing
- Reset values: all outputs 0 (IBUS_A, IBUS_DO, IBUS_BA, WE, REQ, ACTIVE, DONE, ERR, REMAIN); state IDLE.
- Outputs change only on CE_R edges.
- Read data is sampled at the completing CE_R edge. The responder has updated it on the intervening CE_F.
- Minimum throughput: 2 CE_R periods per element. Each BUSY cycle adds 1.
- START to first REQ: 1 CE_R edge.
- Last write completion: DONE=1, ACTIVE=0 and REQ=0 at the same edge.
- No idle cycle between consecutive RD/WR accesses.

## Configuration
- IBUS_COPY_ADDRMODE_EN defined: SM/DM select fixed or increment per side.
- Undefined: SM/DM are ignored and both addresses always increment.

## Test plan
- Long copy to DIVU:
  - Stimulus: SAR=00001000 holding 00000007 and 0000002A, DAR=FFFFFF00, TCR=2, SIZE=2, DM=0.
  - Response: writes 00000007 to FFFFFF00 and 0000002A to FFFFFF04. DONE pulses after exactly 4 CE_R periods; REMAIN ends at 0.
- Byte lanes:
  - Stimulus: SIZE=0, SAR=00002001 holding 11AA3344, DAR=00003003.
  - Response: RD BA=0100; WR BA=0001 with IBUS_DO=AAAAAAAA.
- Wait states:
  - Stimulus: responder holds BUSY for 3 cycles on every access, TCR=1.
  - Response: completion after 8 CE_R periods; A/WE/DO stay stable throughout BUSY.
- Misalignment:
  - Stimulus: SIZE=2, SAR=00001002.
  - Response: ERR pulse, REQ never asserted, ACTIVE stays 0.
- Abort:
  - Stimulus: ABORT during WR with BUSY=1 for 2 cycles, TCR=5.
  - Response: the write completes, then IDLE with ERR pulse and REMAIN=4.
- Fixed destination (macro on):
  - Stimulus: DM=1, DAR=FFFFFF14, TCR=3.
  - Response: all three writes go to FFFFFF14. With the macro off, the writes go to FFFFFF14, FFFFFF18 and FFFFFF1C.

Source files
------------

// File: rtl/ibus_copy_engine_if.sv
// IBUS connection between the copy-engine master and a peripheral responder.
interface ibus_copy_engine_if;
   logic [31:0] ibus_a;
   logic [31:0] ibus_do;
   logic [31:0] ibus_di;
   logic [3:0]  ibus_ba;
   logic        ibus_we;
   logic        ibus_req;
   logic        ibus_busy;

   modport master (
      output ibus_a, ibus_do, ibus_ba, ibus_we, ibus_req,
      input  ibus_di, ibus_busy
   );

   modport slave (
      input  ibus_a, ibus_do, ibus_ba, ibus_we, ibus_req,
      output ibus_di, ibus_busy
   );
endinterface

// File: rtl/ibus_copy_engine.sv
// Single-channel IBUS block-copy master: read source element, write destination, repeat.
// Define IBUS_COPY_ADDRMODE_EN to honour SM/DM (fixed vs increment); otherwise both sides increment.
module ibus_copy_engine #(
   parameter int CNT_W = 24
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce_r,
   input  logic               i_ce_f,
   input  logic               i_res_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [31:0]        i_sar,
   input  logic [31:0]        i_dar,
   input  logic [CNT_W-1:0]   i_tcr,
   input  logic [1:0]         i_size,
   input  logic               i_sm,
   input  logic               i_dm,
   ibus_copy_engine_if.master bus,
   output logic               o_active,
   output logic               o_done,
   output logic               o_err,
   output logic [CNT_W-1:0]   o_remain
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] ofs);
      logic [3:0] lanes;
      case (size)
         2'd0:    lanes = 4'b1000 >> ofs;
         2'd1:    lanes = ofs[1] ? 4'b0011 : 4'b1100;
         2'd2:    lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] ofs);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = ofs[0];
         2'd2:    bad = |ofs;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Big-endian lane pick: offset 0 lives in bits 31:24.
   function automatic logic [31:0] f_extract(input logic [1:0] size, input logic [1:0] ofs,
                                             input logic [31:0] di);
      logic [31:0] elem;
      case (size)
         2'd0: begin
            case (ofs)
               2'd0:    elem = {24'h000000, di[31:24]};
               2'd1:    elem = {24'h000000, di[23:16]};
               2'd2:    elem = {24'h000000, di[15:8]};
               default: elem = {24'h000000, di[7:0]};
            endcase
         end
         2'd1:    elem = ofs[1] ? {16'h0000, di[15:0]} : {16'h0000, di[31:16]};
         default: elem = di;
      endcase
      return elem;
   endfunction

   function automatic logic [31:0] f_replicate(input logic [1:0] size, input logic [31:0] elem);
      logic [31:0] data;
      case (size)
         2'd0:    data = {4{elem[7:0]}};
         2'd1:    data = {2{elem[15:0]}};
         default: data = elem;
      endcase
      return data;
   endfunction

   function automatic logic [31:0] f_step(input logic [1:0] size);
      logic [31:0] step;
      case (size)
         2'd0:    step = 32'd1;
         2'd1:    step = 32'd2;
         2'd2:    step = 32'd4;
         default: step = 32'd0;
      endcase
      return step;
   endfunction

   state_t           r_state, w_state_nx;
   logic [31:0]      r_src, w_src_nx;
   logic [31:0]      r_dst, w_dst_nx;
   logic [CNT_W-1:0] r_remain, w_remain_nx;
   logic [1:0]       r_size, w_size_nx;
   logic             r_sm, w_sm_nx;
   logic             r_dm, w_dm_nx;
   logic             r_abort_pend, w_abort_pend_nx;
   logic [31:0]      r_a, w_a_nx;
   logic [31:0]      r_do, w_do_nx;
   logic [3:0]       r_ba, w_ba_nx;
   logic             r_we, w_we_nx;
   logic             r_req, w_req_nx;
   logic             r_active;
   logic             r_done, w_done_nx;
   logic             r_err, w_err_nx;

   logic [31:0]      w_step;
   logic [31:0]      w_src_adv;
   logic [31:0]      w_dst_adv;
   logic [CNT_W-1:0] w_remain_dec;
   logic [31:0]      w_elem;
   logic             w_unused;

   assign w_step       = f_step(r_size);
   assign w_remain_dec = r_remain - {{(CNT_W-1){1'b0}}, 1'b1};
   assign w_elem       = f_extract(r_size, r_src[1:0], bus.ibus_di);

`ifdef IBUS_COPY_ADDRMODE_EN
   assign w_src_adv = r_sm ? r_src : (r_src + w_step);
   assign w_dst_adv = r_dm ? r_dst : (r_dst + w_step);
   assign w_unused  = i_ce_f;
`else
   assign w_src_adv = r_src + w_step;
   assign w_dst_adv = r_dst + w_step;
   assign w_unused  = ^{i_ce_f, r_sm, r_dm};
`endif

   // Next-state and next-output decode for the IDLE/RD/WR sequencer.
   always_comb begin
      w_state_nx      = r_state;
      w_src_nx        = r_src;
      w_dst_nx        = r_dst;
      w_remain_nx     = r_remain;
      w_size_nx       = r_size;
      w_sm_nx         = r_sm;
      w_dm_nx         = r_dm;
      w_abort_pend_nx = r_abort_pend;
      w_a_nx          = r_a;
      w_do_nx         = r_do;
      w_ba_nx         = r_ba;
      w_we_nx         = r_we;
      w_req_nx        = r_req;
      w_done_nx       = 1'b0;
      w_err_nx        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_src_nx        = i_sar;
               w_dst_nx        = i_dar;
               w_remain_nx     = i_tcr;
               w_size_nx       = i_size;
               w_sm_nx         = i_sm;
               w_dm_nx         = i_dm;
               w_abort_pend_nx = 1'b0;
               if (f_misaligned(i_size, i_sar[1:0]) || f_misaligned(i_size, i_dar[1:0])) begin
                  w_err_nx = 1'b1;
               end else begin
                  w_state_nx = ST_RD;
                  w_req_nx   = 1'b1;
                  w_we_nx    = 1'b0;
                  w_a_nx     = i_sar;
                  w_ba_nx    = f_lanes(i_size, i_sar[1:0]);
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_RD: begin
            if (i_abort) begin
               w_state_nx = ST_IDLE;
               w_err_nx   = 1'b1;
               w_req_nx   = 1'b0;
               w_we_nx    = 1'b0;
               w_ba_nx    = 4'b0000;
            end else if (!bus.ibus_busy) begin
               w_state_nx = ST_WR;
               w_we_nx    = 1'b1;
               w_a_nx     = r_dst;
               w_ba_nx    = f_lanes(r_size, r_dst[1:0]);
               w_do_nx    = f_replicate(r_size, w_elem);
            end else begin
               w_state_nx = ST_RD;
            end
         end
         ST_WR: begin
            // A started write always completes; an abort seen meanwhile is held until then.
            if (!bus.ibus_busy) begin
               w_remain_nx = w_remain_dec;
               w_src_nx    = w_src_adv;
               w_dst_nx    = w_dst_adv;
               if (r_abort_pend || i_abort || (w_remain_dec == '0)) begin
                  w_state_nx      = ST_IDLE;
                  w_req_nx        = 1'b0;
                  w_we_nx         = 1'b0;
                  w_ba_nx         = 4'b0000;
                  w_abort_pend_nx = 1'b0;
                  if (r_abort_pend || i_abort) begin
                     w_err_nx = 1'b1;
                  end else begin
                     w_done_nx = 1'b1;
                  end
               end else begin
                  w_state_nx = ST_RD;
                  w_we_nx    = 1'b0;
                  w_a_nx     = w_src_adv;
                  w_ba_nx    = f_lanes(r_size, w_src_adv[1:0]);
               end
            end else if (i_abort) begin
               w_abort_pend_nx = 1'b1;
            end else begin
               w_state_nx = ST_WR;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_req_nx   = 1'b0;
            w_we_nx    = 1'b0;
            w_ba_nx    = 4'b0000;
         end
      endcase
   end

   // State and output registers, advancing only on CE_R; RES_N acts as a soft reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_src        <= 32'h00000000;
         r_dst        <= 32'h00000000;
         r_remain     <= '0;
         r_size       <= 2'd0;
         r_sm         <= 1'b0;
         r_dm         <= 1'b0;
         r_abort_pend <= 1'b0;
         r_a          <= 32'h00000000;
         r_do         <= 32'h00000000;
         r_ba         <= 4'b0000;
         r_we         <= 1'b0;
         r_req        <= 1'b0;
         r_active     <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else if (i_ce_r) begin
         if (!i_res_n) begin
            r_state      <= ST_IDLE;
            r_src        <= 32'h00000000;
            r_dst        <= 32'h00000000;
            r_remain     <= '0;
            r_size       <= 2'd0;
            r_sm         <= 1'b0;
            r_dm         <= 1'b0;
            r_abort_pend <= 1'b0;
            r_a          <= 32'h00000000;
            r_do         <= 32'h00000000;
            r_ba         <= 4'b0000;
            r_we         <= 1'b0;
            r_req        <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
         end else begin
            r_state      <= w_state_nx;
            r_src        <= w_src_nx;
            r_dst        <= w_dst_nx;
            r_remain     <= w_remain_nx;
            r_size       <= w_size_nx;
            r_sm         <= w_sm_nx;
            r_dm         <= w_dm_nx;
            r_abort_pend <= w_abort_pend_nx;
            r_a          <= w_a_nx;
            r_do         <= w_do_nx;
            r_ba         <= w_ba_nx;
            r_we         <= w_we_nx;
            r_req        <= w_req_nx;
            r_active     <= (w_state_nx != ST_IDLE);
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
         end
      end
   end

   assign bus.ibus_a   = r_a;
   assign bus.ibus_do  = r_do;
   assign bus.ibus_ba  = r_ba;
   assign bus.ibus_we  = r_we;
   assign bus.ibus_req = r_req;
   assign o_active     = r_active;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_remain     = r_remain;

endmodule

// File: tb/tb_ibus_copy_engine.sv
// Directed bench for ibus_copy_engine with a small IBUS responder (memory, wait states, write log).
module tb_ibus_copy_engine;
   logic        clk;
   logic        rst_n;
   logic        ce_r;
   logic        ce_f;
   logic        res_n;
   logic        start;
   logic        abort;
   logic [31:0] sar;
   logic [31:0] dar;
   logic [23:0] tcr;
   logic [1:0]  size;
   logic        sm;
   logic        dm;
   logic        active;
   logic        done;
   logic        err;
   logic [23:0] remain;

   int          n_chk;
   int          n_fail;
   int          busy_cfg;
   int          bsy_cnt;
   int          wcount;
   logic [31:0] log_a [0:31];
   logic [31:0] log_d [0:31];
   logic [3:0]  log_b [0:31];

   ibus_copy_engine_if bus ();

   ibus_copy_engine #(.CNT_W(24)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_ce_r   (ce_r),
      .i_ce_f   (ce_f),
      .i_res_n  (res_n),
      .i_start  (start),
      .i_abort  (abort),
      .i_sar    (sar),
      .i_dar    (dar),
      .i_tcr    (tcr),
      .i_size   (size),
      .i_sm     (sm),
      .i_dm     (dm),
      .bus      (bus),
      .o_active (active),
      .o_done   (done),
      .o_err    (err),
      .o_remain (remain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] d;
      case ({a[31:2], 2'b00})
         32'h00001000: d = 32'h00000007;
         32'h00001004: d = 32'h0000002A;
         32'h00002000: d = 32'h11AA3344;
         default:      d = {a[15:0], 16'hBEEF};
      endcase
      return d;
   endfunction

   assign bus.ibus_di   = (bus.ibus_req && !bus.ibus_we) ? mem_rd(bus.ibus_a) : 32'h00000000;
   assign bus.ibus_busy = bus.ibus_req && (bsy_cnt < busy_cfg);

   initial bsy_cnt = 0;
   initial wcount  = 0;

   // Responder: count wait states per access and log every completed write.
   always @(posedge clk) begin
      if (!bus.ibus_req) begin
         bsy_cnt <= 0;
      end else if (bus.ibus_busy) begin
         bsy_cnt <= bsy_cnt + 1;
      end else begin
         bsy_cnt <= 0;
         if (bus.ibus_we) begin
            log_a[wcount & 31] <= bus.ibus_a;
            log_d[wcount & 31] <= bus.ibus_do;
            log_b[wcount & 31] <= bus.ibus_ba;
            wcount             <= wcount + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until(input int limit, output int cyc);
      cyc = 0;
      while (1) begin
         step();
         cyc++;
         if (done || err) break;
         if (cyc >= limit) begin
            cyc = -1;
            break;
         end
      end
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [23:0] n,
                         input logic [1:0] z, input logic dmode);
      sar   = s;
      dar   = d;
      tcr   = n;
      size  = z;
      dm    = dmode;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int cyc;
      int base;
      n_chk = 0; n_fail = 0; busy_cfg = 0;
      rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0; res_n = 1'b1;
      start = 1'b0; abort = 1'b0; sar = 32'h0; dar = 32'h0; tcr = 24'h0;
      size = 2'd0; sm = 1'b0; dm = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req",    {31'h0, bus.ibus_req}, 32'h0);
      chk("rst_active", {31'h0, active},       32'h0);
      chk("rst_a",      bus.ibus_a,            32'h0);
      chk("rst_remain", {8'h0, remain},        32'h0);
      rst_n = 1'b1;
      step();

      // Long copy to DIVU-style registers
      base = wcount;
      launch(32'h00001000, 32'hFFFFFF00, 24'd2, 2'd2, 1'b0);
      chk("long_req",    {31'h0, bus.ibus_req}, 32'h1);
      chk("long_rd_a",   bus.ibus_a,            32'h00001000);
      chk("long_rd_ba",  {28'h0, bus.ibus_ba},  32'hF);
      chk("long_active", {31'h0, active},       32'h1);
      run_until(20, cyc);
      chk("long_cycles", cyc,                   32'd4);
      chk("long_done",   {31'h0, done},         32'h1);
      chk("long_remain", {8'h0, remain},        32'h0);
      chk("long_idle",   {31'h0, active | bus.ibus_req}, 32'h0);
      chk("long_nwr",    wcount - base,         32'd2);
      chk("long_w0a",    log_a[base & 31],      32'hFFFFFF00);
      chk("long_w0d",    log_d[base & 31],      32'h00000007);
      chk("long_w1a",    log_a[(base + 1) & 31], 32'hFFFFFF04);
      chk("long_w1d",    log_d[(base + 1) & 31], 32'h0000002A);
      step();
      chk("done_pulse",  {31'h0, done},         32'h0);

      // Byte lanes, with START and ABORT together in IDLE (START wins)
      abort = 1'b1;
      launch(32'h00002001, 32'h00003003, 24'd1, 2'd0, 1'b0);
      abort = 1'b0;
      chk("byte_req",    {31'h0, bus.ibus_req}, 32'h1);
      chk("byte_rd_ba",  {28'h0, bus.ibus_ba},  32'h4);
      step();
      chk("byte_we",     {31'h0, bus.ibus_we},  32'h1);
      chk("byte_wr_a",   bus.ibus_a,            32'h00003003);
      chk("byte_wr_ba",  {28'h0, bus.ibus_ba},  32'h1);
      chk("byte_do",     bus.ibus_do,           32'hAAAAAAAA);
      step();
      chk("byte_done",   {31'h0, done},         32'h1);

      // Wait states: 3 BUSY cycles per access
      busy_cfg = 3;
      launch(32'h00001000, 32'hFFFFFF40, 24'd1, 2'd2, 1'b0);
      cyc = 0;
      repeat (3) begin
         step();
         cyc++;
         chk("ws_rd_a",  bus.ibus_a,            32'h00001000);
         chk("ws_rd_we", {31'h0, bus.ibus_we},  32'h0);
      end
      repeat (4) begin
         step();
         cyc++;
         chk("ws_wr_a",  bus.ibus_a,            32'hFFFFFF40);
         chk("ws_wr_do", bus.ibus_do,           32'h00000007);
         chk("ws_wr_we", {31'h0, bus.ibus_we},  32'h1);
      end
      step();
      cyc++;
      chk("ws_done",     {31'h0, done},         32'h1);
      chk("ws_cycles",   cyc,                   32'd8);

      // Misaligned long source
      busy_cfg = 0;
      base = wcount;
      launch(32'h00001002, 32'hFFFFFF00, 24'd1, 2'd2, 1'b0);
      chk("mis_err",     {31'h0, err},          32'h1);
      chk("mis_req",     {31'h0, bus.ibus_req}, 32'h0);
      chk("mis_active",  {31'h0, active},       32'h0);
      step();
      chk("mis_err_pls", {31'h0, err},          32'h0);
      chk("mis_req2",    {31'h0, bus.ibus_req}, 32'h0);

      // Abort during a busy write: the write completes, then ERR
      busy_cfg = 2;
      base = wcount;
      launch(32'h00001000, 32'hFFFFFF80, 24'd5, 2'd2, 1'b0);
      repeat (3) step();
      chk("ab_in_wr",    {31'h0, bus.ibus_we},  32'h1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_still_wr", {31'h0, bus.ibus_we & bus.ibus_req}, 32'h1);
      run_until(20, cyc);
      chk("ab_cycles",   cyc,                   32'd2);
      chk("ab_err",      {31'h0, err},          32'h1);
      chk("ab_nodone",   {31'h0, done},         32'h0);
      chk("ab_remain",   {8'h0, remain},        32'd4);
      chk("ab_nwr",      wcount - base,         32'd1);
      chk("ab_w0a",      log_a[base & 31],      32'hFFFFFF80);

      // TCR=0 wraps to 2^24-1 after the first element; then abort in RD
      busy_cfg = 0;
      base = wcount;
      launch(32'h00001000, 32'hFFFFFF00, 24'd0, 2'd2, 1'b0);
      chk("tc0_remain0", {8'h0, remain},        32'h0);
      step();
      step();
      chk("tc0_remain",  {8'h0, remain},        32'h00FFFFFF);
      chk("tc0_active",  {31'h0, active},       32'h1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("rdab_err",    {31'h0, err},          32'h1);
      chk("rdab_active", {31'h0, active},       32'h0);
      chk("rdab_nwr",    wcount - base,         32'd1);

      // Destination address wrap FFFFFFFC + 4 -> 00000000
      base = wcount;
      launch(32'h00001000, 32'hFFFFFFFC, 24'd2, 2'd2, 1'b0);
      run_until(20, cyc);
      chk("wrap_done",   {31'h0, done},         32'h1);
      chk("wrap_w0a",    log_a[base & 31],      32'hFFFFFFFC);
      chk("wrap_w1a",    log_a[(base + 1) & 31], 32'h00000000);

      // Soft reset mid-access drops REQ
      busy_cfg = 3;
      launch(32'h00001000, 32'hFFFFFF00, 24'd3, 2'd2, 1'b0);
      step();
      step();
      res_n = 1'b0;
      step();
      res_n = 1'b1;
      chk("srst_req",    {31'h0, bus.ibus_req}, 32'h0);
      chk("srst_active", {31'h0, active},       32'h0);
      chk("srst_remain", {8'h0, remain},        32'h0);
      step();

      // Destination mode: fixed with the address-mode build, incrementing otherwise
      busy_cfg = 0;
      base = wcount;
      launch(32'h00001000, 32'hFFFFFF14, 24'd3, 2'd2, 1'b1);
      run_until(30, cyc);
      chk("dm_cycles",   cyc,                   32'd6);
      chk("dm_nwr",      wcount - base,         32'd3);
      chk("dm_w0a",      log_a[base & 31],      32'hFFFFFF14);
`ifdef IBUS_COPY_ADDRMODE_EN
      chk("dm_w1a",      log_a[(base + 1) & 31], 32'hFFFFFF14);
      chk("dm_w2a",      log_a[(base + 2) & 31], 32'hFFFFFF14);
`else
      chk("dm_w1a",      log_a[(base + 1) & 31], 32'hFFFFFF18);
      chk("dm_w2a",      log_a[(base + 2) & 31], 32'hFFFFFF1C);
`endif
      chk("dm_w1d",      log_d[(base + 1) & 31], 32'h0000002A);
      chk("dm_w1b",      {28'h0, log_b[(base + 1) & 31]}, 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
